// File: rtl/tcp_tx_credit_sched_if.sv
// Meta handshake bundle between the vFPGA regions, the credit scheduler and the TCP TX mux.
// The slave modport is the scheduler's view; the master modport is the surrounding environment.
interface tcp_tx_credit_sched_if #(
    parameter  int N_REGIONS = 4,
    parameter  int DATA_BITS = 64,
    localparam int VF_BITS   = (N_REGIONS <= 1) ? 1 : $clog2(N_REGIONS)
);
    logic [N_REGIONS-1:0]           s_meta_valid;
    logic [N_REGIONS-1:0]           s_meta_ready;
    logic [N_REGIONS*DATA_BITS-1:0] s_meta_data;
    logic                           m_meta_valid;
    logic                           m_meta_ready;
    logic [DATA_BITS-1:0]           m_meta_data;
    logic [VF_BITS-1:0]             m_meta_id;

    modport master (
        output s_meta_valid, s_meta_data, m_meta_ready,
        input  s_meta_ready, m_meta_valid, m_meta_data, m_meta_id
    );

    modport slave (
        input  s_meta_valid, s_meta_data, m_meta_ready,
        output s_meta_ready, m_meta_valid, m_meta_data, m_meta_id
    );
endinterface

// File: rtl/tcp_tx_credit_sched.sv
// Credit-limited round-robin scheduler sharing the TCP TX meta path among vFPGA regions.
// Optional per-region grant statistics are built when TCP_TX_SCHED_STATS_EN is defined.
module tcp_tx_credit_sched #(
    parameter  int N_REGIONS       = 4,
    parameter  int DATA_BITS       = 64,
    parameter  int MAX_OUTSTANDING = 16,
    localparam int VF_BITS         = (N_REGIONS <= 1) ? 1 : $clog2(N_REGIONS),
    localparam int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          aclk,
    input  logic                          areset,
    tcp_tx_credit_sched_if.slave          meta,
    input  logic                          cpl_valid,
    input  logic [VF_BITS-1:0]            cpl_id,
    input  logic [CNT_BITS-1:0]           credit_limit,
    output logic [N_REGIONS*CNT_BITS-1:0] outstanding,
    output logic                          cpl_err,
    output logic [N_REGIONS*32-1:0]       stat_grants
);

    typedef enum logic [0:0] {ST_IDLE, ST_SEND} state_t;

    function automatic logic [CNT_BITS-1:0] clamp_limit(input logic [CNT_BITS-1:0] lim);
        if (int'(lim) > MAX_OUTSTANDING) return CNT_BITS'(MAX_OUTSTANDING);
        return lim;
    endfunction

    state_t                 state;
    logic [VF_BITS-1:0]     rr_ptr;
    logic [CNT_BITS-1:0]    cnt [N_REGIONS];
    logic [DATA_BITS-1:0]   data_p1;
    logic [VF_BITS-1:0]     id_p1;
    logic                   vld_p1;

    logic [CNT_BITS-1:0]    eff_limit;
    logic [N_REGIONS-1:0]   eligible;
    logic [N_REGIONS-1:0]   ready_vec;
    logic [N_REGIONS-1:0]   cpl_dec;
    logic [VF_BITS-1:0]     scan;
    logic [VF_BITS-1:0]     winner;
    logic                   found;
    logic                   grant;
    logic                   cpl_bad;

    assign eff_limit = clamp_limit(credit_limit);

    // Arbitration: first eligible region at or after rr_ptr
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            eligible[i] = meta.s_meta_valid[i] && (cnt[i] < eff_limit);
        end
        found  = 1'b0;
        winner = '0;
        scan   = '0;
        for (int k = 0; k < N_REGIONS; k++) begin
            scan = VF_BITS'((int'(rr_ptr) + k) % N_REGIONS);
            if (!found && eligible[scan]) begin
                found  = 1'b1;
                winner = scan;
            end
        end
    end

    assign grant = (state == ST_IDLE) && found && !areset;

    always_comb begin
        ready_vec = '0;
        if (grant) ready_vec[winner] = 1'b1;
    end

    // A completion against an empty counter or an unknown region decrements nothing
    always_comb begin
        cpl_dec = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            cpl_dec[i] = cpl_valid && (cpl_id == VF_BITS'(i)) && (cnt[i] != '0);
        end
    end

    assign cpl_bad = cpl_valid && !(|cpl_dec);

    // Stage p0 -> p1: grant capture into the output register
    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            data_p1 <= '0;
            id_p1   <= '0;
            vld_p1  <= 1'b0;
            cpl_err <= 1'b0;
            for (int i = 0; i < N_REGIONS; i++) cnt[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        data_p1 <= meta.s_meta_data[int'(winner)*DATA_BITS +: DATA_BITS];
                        id_p1   <= winner;
                        vld_p1  <= 1'b1;
                        state   <= ST_SEND;
                        if (int'(winner) == N_REGIONS - 1) rr_ptr <= '0;
                        else                               rr_ptr <= winner + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (meta.m_meta_ready) begin
                        vld_p1 <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    vld_p1 <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase

            for (int i = 0; i < N_REGIONS; i++) begin
                case ({ready_vec[i], cpl_dec[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: cnt[i] <= cnt[i];
                endcase
            end

            if (cpl_bad) cpl_err <= 1'b1;
        end
    end

    assign meta.s_meta_ready = ready_vec;
    assign meta.m_meta_valid = vld_p1;
    assign meta.m_meta_data  = data_p1;
    assign meta.m_meta_id    = id_p1;

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            outstanding[i*CNT_BITS +: CNT_BITS] = cnt[i];
        end
    end

`ifdef TCP_TX_SCHED_STATS_EN
    logic [31:0] grant_cnt [N_REGIONS];

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < N_REGIONS; i++) grant_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_REGIONS; i++) begin
                if (ready_vec[i]) grant_cnt[i] <= grant_cnt[i] + 32'd1;
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            stat_grants[i*32 +: 32] = grant_cnt[i];
        end
    end
`else
    assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_tcp_tx_credit_sched.sv
// Bench for tcp_tx_credit_sched: directed scenarios plus random traffic against a
// cycle-level behavioural model of the credit/round-robin rules.
module tb_tcp_tx_credit_sched;
    localparam int N    = 4;
    localparam int DW   = 64;
    localparam int MAXO = 16;
    localparam int VF   = 2;
    localparam int CW   = 5;

    logic              aclk = 1'b0;
    logic              areset;
    logic              cpl_valid;
    logic [VF-1:0]     cpl_id;
    logic [CW-1:0]     credit_limit;
    logic [N*CW-1:0]   outstanding;
    logic              cpl_err;
    logic [N*32-1:0]   stat_grants;

    tcp_tx_credit_sched_if #(.N_REGIONS(N), .DATA_BITS(DW)) bus ();

    tcp_tx_credit_sched #(.N_REGIONS(N), .DATA_BITS(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .meta         (bus),
        .cpl_valid    (cpl_valid),
        .cpl_id       (cpl_id),
        .credit_limit (credit_limit),
        .outstanding  (outstanding),
        .cpl_err      (cpl_err),
        .stat_grants  (stat_grants)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: in-flight counts, round-robin start, held meta, sticky error
    int          m_cnt [N];
    int          m_rr;
    bit          m_hold;
    logic [DW-1:0] m_data;
    int          m_id;
    bit          m_err;
    logic [31:0] m_stat [N];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lim_now();
        return (int'(credit_limit) > MAXO) ? MAXO : int'(credit_limit);
    endfunction

    function automatic int pick();
        int r;
        for (int k = 0; k < N; k++) begin
            r = (m_rr + k) % N;
            if (bus.s_meta_valid[r] && m_cnt[r] < lim_now()) return r;
        end
        return -1;
    endfunction

    function automatic logic [31:0] stat_exp(input int r);
`ifdef TCP_TX_SCHED_STATS_EN
        return m_stat[r];
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 0;
            m_stat[i] = '0;
        end
        m_rr = 0; m_hold = 0; m_data = '0; m_id = 0; m_err = 0;
    endtask

    task automatic check_model();
        int w;
        logic [N-1:0] exp_rdy;
        w = pick();
        exp_rdy = '0;
        if (!areset && !m_hold && w >= 0) exp_rdy[w] = 1'b1;
        check_eq("s_meta_ready", bus.s_meta_ready, exp_rdy);
        check_eq("m_meta_valid", bus.m_meta_valid, m_hold);
        if (m_hold) begin
            check_eq("m_meta_data", bus.m_meta_data, m_data);
            check_eq("m_meta_id", bus.m_meta_id, m_id);
        end
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("outstanding[%0d]", i), outstanding[i*CW +: CW], m_cnt[i]);
            check_eq($sformatf("stat_grants[%0d]", i), stat_grants[i*32 +: 32], stat_exp(i));
        end
        check_eq("cpl_err", cpl_err, m_err);
    endtask

    task automatic model_update();
        int w;
        int snap [N];
        if (areset) begin
            model_reset();
            return;
        end
        snap = m_cnt;
        w = m_hold ? -1 : pick();
        if (w >= 0) begin
            m_hold = 1;
            m_data = bus.s_meta_data[w*DW +: DW];
            m_id   = w;
            m_cnt[w]++;
            m_stat[w]++;
            m_rr = (w + 1) % N;
        end else if (m_hold && bus.m_meta_ready) begin
            m_hold = 0;
        end
        if (cpl_valid) begin
            if (int'(cpl_id) < N && snap[cpl_id] > 0) m_cnt[cpl_id]--;
            else m_err = 1;
        end
    endtask

    task automatic step();
        @(negedge aclk);
        check_model();
        @(posedge aclk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        bus.s_meta_valid = '0;
        bus.m_meta_ready = 1'b1;
        cpl_valid = 1'b0;
        cpl_id = '0;
        credit_limit = CW'(MAXO);
        for (int i = 0; i < N; i++) bus.s_meta_data[i*DW +: DW] = {32'hA000_0000 + 32'(i), $urandom};
    endtask

    task automatic do_reset();
        idle_inputs();
        areset = 1'b1;
        step();
        areset = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] held_data;
        int            g;

        idle_inputs();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        model_reset();
        areset = 1'b0;

        check_eq("rst_m_valid", bus.m_meta_valid, 0);
        check_eq("rst_m_data", bus.m_meta_data, 0);
        check_eq("rst_m_id", bus.m_meta_id, 0);
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_cpl_err", cpl_err, 0);

        // Limit 2, one region, three requests
        credit_limit = 5'd2;
        bus.s_meta_valid = 4'b0001;
        repeat (6) step();
        check_eq("lim_outstanding0", outstanding[0 +: CW], 2);
        check_eq("lim_ready0", bus.s_meta_ready[0], 0);
        cpl_valid = 1'b1; cpl_id = 2'd0;
        step();
        check_eq("lim_after_cpl", outstanding[0 +: CW], 1);
        cpl_valid = 1'b0;
        step();
        check_eq("lim_third_valid", bus.m_meta_valid, 1);
        check_eq("lim_third_id", bus.m_meta_id, 0);

        // Round robin with all regions requesting
        do_reset();
        bus.s_meta_valid = 4'b1111;
        g = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (bus.m_meta_valid) begin
                check_eq("rr_order", bus.m_meta_id, g % N);
                g++;
            end
        end
        check_eq("rr_grants", g, 8);

        // Downstream stall holds the output register
        do_reset();
        bus.s_meta_valid = 4'b0100;
        bus.m_meta_ready = 1'b0;
        step();
        held_data = bus.m_meta_data;
        bus.s_meta_valid = 4'b1111;
        repeat (10) begin
            for (int i = 0; i < N; i++) bus.s_meta_data[i*DW +: DW] = {$urandom, $urandom};
            step();
        end
        check_eq("stall_data", bus.m_meta_data, held_data);
        check_eq("stall_id", bus.m_meta_id, 2);
        check_eq("stall_ready", bus.s_meta_ready, 0);
        bus.m_meta_ready = 1'b1;
        step();

        // Grant and completion to region 1 in the same cycle
        do_reset();
        bus.s_meta_valid = 4'b0010;
        repeat (6) step();
        check_eq("same_pre", outstanding[1*CW +: CW], 3);
        cpl_valid = 1'b1; cpl_id = 2'd1;
        step();
        cpl_valid = 1'b0;
        bus.s_meta_valid = '0;
        check_eq("same_net", outstanding[1*CW +: CW], 3);

        // Erroneous completion, then reset while holding a meta
        do_reset();
        cpl_valid = 1'b1; cpl_id = 2'd2;
        step();
        cpl_valid = 1'b0;
        step();
        check_eq("err_sticky", cpl_err, 1);
        check_eq("err_cnt2", outstanding[2*CW +: CW], 0);
        bus.s_meta_valid = 4'b0100;
        bus.m_meta_ready = 1'b0;
        step();
        check_eq("pre_rst_valid", bus.m_meta_valid, 1);
        areset = 1'b1;
        step();
        areset = 1'b0;
        bus.s_meta_valid = '0;
        check_eq("mid_rst_valid", bus.m_meta_valid, 0);
        check_eq("mid_rst_data", bus.m_meta_data, 0);
        check_eq("mid_rst_err", cpl_err, 0);
        check_eq("mid_rst_cnt", outstanding, 0);
        bus.m_meta_ready = 1'b1;

        // Five grants to region 3
        do_reset();
        bus.s_meta_valid = 4'b1000;
        repeat (10) step();
        bus.s_meta_valid = '0;
        step();
`ifdef TCP_TX_SCHED_STATS_EN
        check_eq("stat3", stat_grants[3*32 +: 32], 5);
`else
        check_eq("stat3", stat_grants[3*32 +: 32], 0);
`endif

        // Zero limit: no grants
        do_reset();
        credit_limit = '0;
        bus.s_meta_valid = 4'b1111;
        repeat (4) step();
        check_eq("zero_lim_valid", bus.m_meta_valid, 0);

        // Random traffic
        do_reset();
        credit_limit = 5'd4;
        for (int c = 0; c < 2000; c++) begin
            bus.s_meta_valid = N'($urandom);
            for (int i = 0; i < N; i++) bus.s_meta_data[i*DW +: DW] = {$urandom, $urandom};
            bus.m_meta_ready = ($urandom_range(0, 3) != 0);
            cpl_valid = ($urandom_range(0, 2) == 0);
            cpl_id = VF'($urandom_range(0, N - 1));
            if ($urandom_range(0, 39) == 0) credit_limit = CW'($urandom_range(0, 31));
            areset = ($urandom_range(0, 299) == 0);
            step();
        end
        areset = 1'b0;
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
